// File: rtl/uart_pkg.sv
// Shared UART definitions for the memory-dump transmitter and the receiver rewrite.
// The CKSUM state exists only when UART_TX_CHECKSUM_EN is defined.
package uart_pkg;

  localparam int CLKS_PER_BIT_115200 = 868;
  localparam int BYTES_PER_WORD      = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    START,
    DATA,
    STOP
`ifdef UART_TX_CHECKSUM_EN
    ,
    CKSUM
`endif
  } tx_state_t;

endpackage

// File: rtl/uart_baud_timer.sv
// Bit-period timer shared by the UART TX and RX paths.
// A load starts a down-count from CLKS_PER_BIT-1. The tick fires in the cycle the
// count reaches zero, so load-to-tick spans exactly CLKS_PER_BIT cycles. Loading in
// the tick cycle chains bits back to back without drift.
module uart_baud_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic tick
);

  localparam int               CNT_W  = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             armed_q, armed_d;

  // armed keeps an idle counter sitting at zero from producing ticks.
  assign tick = armed_q && (cnt_q == '0);

  // Next count: reload wins, otherwise count down and disarm once zero is reached.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load) begin
      cnt_d   = RELOAD;
      armed_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      armed_d = 1'b0;
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/uart_mem_tx.sv
// Memory-dump UART transmitter.
// On an accepted start it reads wordCount words from startAddr. Each word goes out as
// four 8N1 bytes, least significant byte first. This matches the loader's packing, so
// a dump can be reloaded unchanged.
// Optional feature: define UART_TX_CHECKSUM_EN to append one 8N1 byte after the last
// word. That byte carries the XOR of all data bytes sent.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high, waiting for start
// FETCH | readAddr presented to memory
// WAIT  | memory latency; readData captured into the word shifter
// START | start bit (line low)
// DATA  | data bits, LSB first
// STOP  | stop bit (line high); choose next byte / next word / finish
// CKSUM | (checksum build) load checksum byte into the shifter
module uart_mem_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int ADDR_W       = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] startAddr,
  input  logic [ADDR_W-1:0] wordCount,
  output logic [ADDR_W-1:0] readAddr,
  input  logic [31:0]       readData,
  output logic              serialOut,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  tx_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [31:0]       shift_q, shift_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              serial_q, serial_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef UART_TX_CHECKSUM_EN
  logic [7:0]        cks_q, cks_d;
  logic              cks_phase_q, cks_phase_d;
`endif

  logic       baud_load;
  logic       baud_tick;
  logic       start_ok;
  logic [7:0] next_byte;

  uart_baud_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .load (baud_load),
    .tick (baud_tick)
  );

  // A start landing in the done cycle is dropped, even though busy is already low.
  assign start_ok = start && (state_q == IDLE) && !done_q;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    bit_idx_d  = bit_idx_q;
    done_d     = 1'b0;
    baud_load  = 1'b0;
`ifdef UART_TX_CHECKSUM_EN
    cks_d       = cks_q;
    cks_phase_d = cks_phase_q;
`endif

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          if (wordCount != '0) begin
            state_d = FETCH;
            addr_d  = startAddr;
            count_d = wordCount;
`ifdef UART_TX_CHECKSUM_EN
            cks_d       = '0;
            cks_phase_d = 1'b0;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end

      FETCH: state_d = WAIT;

      WAIT: begin
        shift_d    = readData;
        byte_idx_d = '0;
        state_d    = START;
        baud_load  = 1'b1;
`ifdef UART_TX_CHECKSUM_EN
        cks_d = cks_q ^ readData[7:0];
`endif
      end

      START: begin
        if (baud_tick) begin
          state_d   = DATA;
          bit_idx_d = '0;
          baud_load = 1'b1;
        end
      end

      DATA: begin
        if (baud_tick) begin
          baud_load = 1'b1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (baud_tick) begin
`ifdef UART_TX_CHECKSUM_EN
          if (cks_phase_q) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            cks_phase_d = 1'b0;
          end else
`endif
          if (byte_idx_q != LAST_BYTE) begin
            state_d    = START;
            byte_idx_d = byte_idx_q + 2'd1;
            shift_d    = {8'h00, shift_q[31:8]};
            baud_load  = 1'b1;
`ifdef UART_TX_CHECKSUM_EN
            cks_d = cks_q ^ shift_q[15:8];
`endif
          end else if (count_q > ADDR_W'(1)) begin
            state_d = FETCH;
            addr_d  = addr_q + ADDR_W'(1);
            count_d = count_q - ADDR_W'(1);
          end else begin
`ifdef UART_TX_CHECKSUM_EN
            state_d = CKSUM;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end

`ifdef UART_TX_CHECKSUM_EN
      CKSUM: begin
        shift_d     = {24'h0, cks_q};
        cks_phase_d = 1'b1;
        state_d     = START;
        baud_load   = 1'b1;
      end
`endif

      default: state_d = IDLE;
    endcase

    // Outputs are derived from the next state so they change with the state register.
    next_byte = shift_d[7:0];
    serial_d  = 1'b1;
    if (state_d == START) begin
      serial_d = 1'b0;
    end else if (state_d == DATA) begin
      serial_d = next_byte[bit_idx_d];
    end
    busy_d = (state_d != IDLE);
  end

  // FSM state, datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      shift_q    <= '0;
      byte_idx_q <= '0;
      bit_idx_q  <= '0;
      serial_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_CHECKSUM_EN
      cks_q       <= '0;
      cks_phase_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      bit_idx_q  <= bit_idx_d;
      serial_q   <= serial_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_CHECKSUM_EN
      cks_q       <= cks_d;
      cks_phase_q <= cks_phase_d;
`endif
    end
  end

  assign readAddr  = addr_q;
  assign serialOut = serial_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_uart_mem_tx.sv
// Bench for uart_mem_tx. A mid-bit-sampling 8N1 receiver and a read-address monitor
// pop expected values that each dump pushes from the bench's memory model.
module tb_uart_mem_tx;

  localparam int CLKS = 16;
  localparam int AW   = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] startAddr;
  logic [AW-1:0] wordCount;
  logic [AW-1:0] readAddr;
  logic [31:0]   readData;
  logic          serialOut;
  logic          busy;
  logic          done;

  logic [31:0]   mem [0:4095];
  logic [7:0]    exp_q [$];
  logic [AW-1:0] addr_q [$];
  int            n_checks = 0;
  int            n_errors = 0;
  bit            rx_abort;

  always #5 clk = ~clk;

  uart_mem_tx #(
    .CLKS_PER_BIT(CLKS),
    .ADDR_W      (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .startAddr(startAddr),
    .wordCount(wordCount),
    .readAddr (readAddr),
    .readData (readData),
    .serialOut(serialOut),
    .busy     (busy),
    .done     (done)
  );

  // synchronous memory: data one cycle after address
  always @(posedge clk) readData <= mem[readAddr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rx_wait(input int n);
    for (int k = 0; k < n; k++) begin
      if (rx_abort) break;
      @(negedge clk);
      if (reset) rx_abort = 1'b1;
    end
  endtask

  // behavioural 8N1 receiver
  initial begin : rx_mon
    logic [7:0] rx_byte;
    logic       stop_bit;
    rx_abort = 1'b0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1 && serialOut === 1'b0) begin
        rx_abort = 1'b0;
        rx_byte  = '0;
        rx_wait(CLKS / 2);
        if (!rx_abort) chk("rx_start_bit", 32'(serialOut), 32'd0);
        for (int b = 0; b < 8; b++) begin
          rx_wait(CLKS);
          rx_byte[b] = serialOut;
        end
        rx_wait(CLKS);
        stop_bit = serialOut;
        if (!rx_abort) begin
          chk("rx_stop_bit", 32'(stop_bit), 32'd1);
          chk("rx_byte_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) chk("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // read address monitor: every change while busy must be the next expected fetch
  initial begin : ra_mon
    logic [AW-1:0] prev_ra;
    prev_ra = '0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1 && reset !== 1'b1 && readAddr !== prev_ra) begin
        chk("read_addr_expected", 32'(addr_q.size() != 0), 32'd1);
        if (addr_q.size() != 0) chk("read_addr", 32'(readAddr), 32'(addr_q.pop_front()));
      end
      prev_ra = readAddr;
    end
  end

  task automatic run_dump(input logic [AW-1:0] addr, input logic [AW-1:0] wc,
                          input int glitch_at, input int reset_at);
    int          lat;
    int          exp_lat;
    int          limit;
    int          n_done;
    logic [31:0] w;
`ifdef UART_TX_CHECKSUM_EN
    logic [7:0]  x;
    x = '0;
`endif
    for (int i = 0; i < int'(wc); i++) begin
      w = mem[addr + AW'(i)];
      addr_q.push_back(addr + AW'(i));
      for (int b = 0; b < 4; b++) begin
        exp_q.push_back(w[8*b +: 8]);
`ifdef UART_TX_CHECKSUM_EN
        x ^= w[8*b +: 8];
`endif
      end
    end
    exp_lat = 0;
    if (wc != 0) exp_lat = 2 + int'(wc) * 40 * CLKS + (int'(wc) - 1) * 2;
`ifdef UART_TX_CHECKSUM_EN
    if (wc != 0) begin
      exp_q.push_back(x);
      exp_lat += 1 + 10 * CLKS;
    end
`endif
    limit = exp_lat + 50;

    @(negedge clk);
    startAddr = addr;
    wordCount = wc;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    startAddr = 12'h5A5;
    wordCount = 12'h00F;
    lat       = 0;
    chk("busy_on_accept", 32'(busy), 32'(wc != 0));
    if (wc == 0) chk("line_idle_wc0", 32'(serialOut), 32'd1);

    while (!done && lat < limit) begin
      if (lat == glitch_at) begin
        start     = 1'b1;
        startAddr = 12'h3C3;
        wordCount = 12'h007;
      end
      if (lat == reset_at) begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_line_idle", 32'(serialOut), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        addr_q.delete();
        n_done = 0;
        repeat (4 * CLKS) begin
          @(posedge clk);
          #1;
          if (done) n_done++;
        end
        chk("no_done_after_reset", 32'(n_done), 32'd0);
        return;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      lat++;
    end

    chk("done_latency", 32'(lat), 32'(exp_lat));
    chk("busy_in_done", 32'(busy), 32'd0);
    chk("all_bytes_sent", 32'(exp_q.size()), 32'd0);
    chk("all_reads_seen", 32'(addr_q.size()), 32'd0);

    // a start during the done cycle must be dropped
    start     = 1'b1;
    startAddr = 12'h0AA;
    wordCount = 12'h003;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("start_in_done_dropped", 32'(busy), 32'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'(i) * 32'h9E37_79B1;
    mem[12'h010] = 32'h4433_2211;
    mem[12'hFFF] = 32'hA1B2_C3D4;
    mem[12'h000] = 32'h0F1E_2D3C;
    mem[12'h020] = 32'hDEAD_BEEF;
    mem[12'h100] = 32'h7E81_0042;
    mem[12'h101] = 32'h1357_9BDF;
    mem[12'h030] = 32'h5AA5_C33C;

    reset     = 1'b1;
    start     = 1'b0;
    startAddr = '0;
    wordCount = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_serial", 32'(serialOut), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_read_addr", 32'(readAddr), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // single word, byte order 11 22 33 44
    run_dump(12'h010, 12'd1, -1, -1);
    // empty dump: immediate done, no line activity, address untouched
    run_dump(12'h234, 12'd0, -1, -1);
    chk("ra_hold_wc0", 32'(readAddr), 32'h010);
    // address wrap 0xFFF -> 0x000
    run_dump(12'hFFF, 12'd2, -1, -1);
    // stray start in the middle of data bit 3 of byte 0
    run_dump(12'h020, 12'd1, 2 + 4 * CLKS + CLKS / 2, -1);
    // reset during data bit 3 of byte 1
    run_dump(12'h100, 12'd2, -1, 2 + 14 * CLKS + CLKS / 2);
    // normal operation after the abandoned frame
    run_dump(12'h030, 12'd1, -1, -1);

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
